// File: rtl/seq_detect_param_if.sv
// Serial bit stream, configuration strobe and match outputs of the sequence detector.
interface seq_detect_param_if #(
  parameter int W    = 4,
  parameter int RUNW = 4,
  parameter int CNTW = 8
);
  logic            in_valid;
  logic            in_bit;
  logic            cfg_load;
  logic            cfg_mode;
  logic            cfg_overlap;
  logic [W-1:0]    cfg_pattern;
  logic [RUNW-1:0] cfg_run_len;
  logic            match_now;
  logic            match_q;
  logic [CNTW-1:0] match_count;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_mode, cfg_overlap, cfg_pattern, cfg_run_len,
    input  match_now, match_q, match_count
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_mode, cfg_overlap, cfg_pattern, cfg_run_len,
    output match_now, match_q, match_count
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: W-bit pattern match or run of >= K ones,
// overlapping or non-overlapping, with Mealy/Moore match flags and a saturating count.
module seq_detect_param #(
  parameter int W    = 4,
  parameter int RUNW = 4,
  parameter int CNTW = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);
  localparam int FILLW = $clog2(W + 1);
  localparam logic [FILLW-1:0] FILL_FULL = FILLW'(W);
  localparam logic [FILLW-1:0] FILL_ARM  = FILLW'(W - 1);

  // Shadow configuration
  logic            mode;
  logic            overlap;
  logic [W-1:0]    pattern;
  logic [RUNW-1:0] run_len;

  // Detection state; only the W-1 most recent bits are ever compared, the
  // incoming bit completes the W-bit window.
  logic [W-2:0]    hist;
  logic [FILLW-1:0] fill;
  logic [RUNW-1:0] run;
  logic [CNTW-1:0] count;
  logic            hit_q;

  logic            accept;
  logic            hit;
  logic [W-1:0]    window;
  logic [RUNW:0]   run_inc;
  logic [RUNW:0]   run_need;

  // Mealy match decode from current state and the bit on the wire
  always_comb begin
    accept   = 1'b0;
    hit      = 1'b0;
    window   = {hist, bus.in_bit};
    run_inc  = {1'b0, run} + (RUNW+1)'(1);
    run_need = (run_len == '0) ? (RUNW+1)'(1) : {1'b0, run_len};
    accept   = rst && bus.in_valid && !bus.cfg_load;
    if (accept) begin
      if (mode) hit = bus.in_bit && (run_inc >= run_need);
      else      hit = (fill >= FILL_ARM) && (window == pattern);
    end
  end

  // Shadow config: defaults give the legacy two-ones detector once run mode is chosen
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode    <= 1'b0;
      overlap <= 1'b1;
      pattern <= '0;
      run_len <= RUNW'(2);
    end else if (bus.cfg_load) begin
      mode    <= bus.cfg_mode;
      overlap <= bus.cfg_overlap;
      pattern <= bus.cfg_pattern;
      run_len <= bus.cfg_run_len;
    end
  end

  // History, fill and run tracking; a non-overlapping match restarts fill and run
  always_ff @(posedge clk) begin
    if (!rst || bus.cfg_load) begin
      hist <= '0;
      fill <= '0;
      run  <= '0;
    end else if (accept) begin
      hist <= window[W-2:0];
      if (hit && !overlap) begin
        fill <= '0;
        run  <= '0;
      end else begin
        fill <= (fill == FILL_FULL) ? fill : fill + FILLW'(1);
        if (!bus.in_bit)    run <= '0;
        else if (run != '1) run <= run + RUNW'(1);
      end
    end
  end

  // Registered match flag and saturating match counter
  always_ff @(posedge clk) begin
    if (!rst || bus.cfg_load) begin
      hit_q <= 1'b0;
      count <= '0;
    end else begin
      hit_q <= hit;
      if (hit && count != '1) count <= count + CNTW'(1);
    end
  end

  assign bus.match_now   = hit;
  assign bus.match_q     = hit_q;
  assign bus.match_count = count;
endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a bit-queue reference model checked every cycle on two
// instances (8-bit and 2-bit counters), plus literal expectations per directed stream.
module tb_seq_detect_param;
  localparam int W      = 4;
  localparam int RUNW   = 4;
  localparam int CNTW   = 8;
  localparam int CNTW_S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid, in_bit, cfg_load, cfg_mode, cfg_overlap;
  logic [W-1:0]    cfg_pattern;
  logic [RUNW-1:0] cfg_run_len;

  seq_detect_param_if #(.W(W), .RUNW(RUNW), .CNTW(CNTW))   bus_a ();
  seq_detect_param_if #(.W(W), .RUNW(RUNW), .CNTW(CNTW_S)) bus_b ();

  assign bus_a.in_valid = in_valid;    assign bus_b.in_valid = in_valid;
  assign bus_a.in_bit = in_bit;        assign bus_b.in_bit = in_bit;
  assign bus_a.cfg_load = cfg_load;    assign bus_b.cfg_load = cfg_load;
  assign bus_a.cfg_mode = cfg_mode;    assign bus_b.cfg_mode = cfg_mode;
  assign bus_a.cfg_overlap = cfg_overlap; assign bus_b.cfg_overlap = cfg_overlap;
  assign bus_a.cfg_pattern = cfg_pattern; assign bus_b.cfg_pattern = cfg_pattern;
  assign bus_a.cfg_run_len = cfg_run_len; assign bus_b.cfg_run_len = cfg_run_len;

  seq_detect_param #(.W(W), .RUNW(RUNW), .CNTW(CNTW)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  seq_detect_param #(.W(W), .RUNW(RUNW), .CNTW(CNTW_S)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits accepted since the last clear, plus an unbounded match tally
  bit            m_mode    = 1'b0;
  bit            m_overlap = 1'b1;
  logic [W-1:0]  m_pattern = '0;
  logic [RUNW-1:0] m_run_len = RUNW'(2);
  bit            hq[$];
  int            cnt = 0;
  bit            mq = 1'b0;
  logic [31:0]   now_log = '0;

  function automatic bit model_now();
    int ones;
    int k;
    if (!rst || !in_valid || cfg_load) return 1'b0;
    if (!m_mode) begin
      if (hq.size() < W - 1) return 1'b0;
      for (int i = 0; i < W - 1; i++)
        if (hq[hq.size() - (W - 1) + i] != m_pattern[W-1-i]) return 1'b0;
      return in_bit == m_pattern[0];
    end
    ones = 0;
    for (int i = hq.size() - 1; i >= 0; i--) begin
      if (!hq[i]) break;
      ones++;
    end
    k = (m_run_len == 0) ? 1 : int'(m_run_len);
    return in_bit && (ones + 1 >= k);
  endfunction

  always @(negedge clk) begin
    bit e;
    #2;
    e = model_now();
    check("now_a",   bus_a.match_now,   e);
    check("q_a",     bus_a.match_q,     mq);
    check("count_a", bus_a.match_count, (cnt > 255) ? 255 : cnt);
    check("now_b",   bus_b.match_now,   e);
    check("q_b",     bus_b.match_q,     mq);
    check("count_b", bus_b.match_count, (cnt > 3) ? 3 : cnt);
    if (rst && in_valid && !cfg_load) now_log = {now_log[30:0], bus_a.match_now};
    if (!rst) begin
      m_mode = 1'b0; m_overlap = 1'b1; m_pattern = '0; m_run_len = RUNW'(2);
      hq.delete(); cnt = 0; mq = 1'b0;
    end else if (cfg_load) begin
      m_mode = cfg_mode; m_overlap = cfg_overlap; m_pattern = cfg_pattern; m_run_len = cfg_run_len;
      hq.delete(); cnt = 0; mq = 1'b0;
    end else if (in_valid) begin
      if (e && !m_overlap) hq.delete();
      else hq.push_back(in_bit);
      if (e) cnt++;
      mq = e;
    end else begin
      mq = 1'b0;
    end
  end

  // '1'/'0' are accepted bits, '_' is an idle cycle
  task automatic stream(input string s);
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      cfg_load = 1'b0;
      in_valid = (c != "_");
      in_bit   = (c == "1");
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Config values are scrambled after the strobe so only the shadow copy can be used
  task automatic load_cfg(input logic mode, input logic ov, input logic [W-1:0] pat,
                          input logic [RUNW-1:0] len, input logic v, input logic b);
    cfg_mode = mode; cfg_overlap = ov; cfg_pattern = pat; cfg_run_len = len;
    cfg_load = 1'b1; in_valid = v; in_bit = b;
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    cfg_pattern = ~pat; cfg_run_len = ~len; cfg_overlap = ~ov;
    now_log = '0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
    cfg_mode = 1'b0; cfg_overlap = 1'b0; cfg_pattern = '0; cfg_run_len = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    now_log = '0;

    // Reset defaults: pattern mode, pattern 0000, overlapping
    stream("0000");
    check("default_now", now_log, 32'b0001);
    check("default_count", bus_a.match_count, 1);

    // Legacy two-ones behaviour
    load_cfg(1'b1, 1'b1, 4'b0000, 4'd2, 1'b0, 1'b0);
    stream("0110111");
    check("legacy_now", now_log, 32'b0010011);
    check("legacy_count_a", bus_a.match_count, 3);
    check("legacy_count_b", bus_b.match_count, 3);
    check("legacy_q", bus_a.match_q, 1);

    // Run mode, non-overlapping
    load_cfg(1'b1, 1'b0, 4'b0000, 4'd2, 1'b0, 1'b0);
    stream("0110111");
    check("run_nov_now", now_log, 32'b0010010);
    check("run_nov_count", bus_a.match_count, 2);

    // Pattern 1011 overlapping and non-overlapping
    load_cfg(1'b0, 1'b1, 4'b1011, 4'd0, 1'b0, 1'b0);
    stream("1011011");
    check("pat_ov_now", now_log, 32'b0001001);
    check("pat_ov_count", bus_a.match_count, 2);
    load_cfg(1'b0, 1'b0, 4'b1011, 4'd0, 1'b0, 1'b0);
    stream("1011011");
    check("pat_nov_now", now_log, 32'b0001000);
    check("pat_nov_count", bus_a.match_count, 1);

    // Idle gaps inside the pattern
    load_cfg(1'b0, 1'b1, 4'b1011, 4'd0, 1'b0, 1'b0);
    stream("1_0__11");
    check("gap_now", now_log, 32'b0001);
    check("gap_count", bus_a.match_count, 1);

    // cfg_load with a valid bit: bit dropped, history cleared
    load_cfg(1'b0, 1'b1, 4'b1011, 4'd0, 1'b1, 1'b1);
    check("load_clear_count", bus_a.match_count, 0);
    stream("011");
    check("load_drop_now", now_log, 32'b000);
    check("load_drop_count", bus_a.match_count, 0);

    // Counter saturation on the 2-bit instance
    load_cfg(1'b1, 1'b1, 4'b0000, 4'd1, 1'b0, 1'b0);
    stream("111111");
    check("sat_now", now_log, 32'b111111);
    check("sat_count_a", bus_a.match_count, 6);
    check("sat_count_b", bus_b.match_count, 3);

    // Run length 0 behaves as 1
    load_cfg(1'b1, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0);
    stream("0111");
    check("len0_now", now_log, 32'b0111);

    // Long run past the run counter's saturation point
    load_cfg(1'b1, 1'b1, 4'b0000, 4'd15, 1'b0, 1'b0);
    stream("11111111111111111111");
    check("longrun_now", now_log, 32'h0003F);
    check("longrun_count_a", bus_a.match_count, 6);
    check("longrun_count_b", bus_b.match_count, 3);

    // Reset mid-pattern discards history and restores default config (pattern 0000)
    load_cfg(1'b0, 1'b1, 4'b1011, 4'd0, 1'b0, 1'b0);
    stream("101");
    rst = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
    check("rst_count", bus_a.match_count, 0);
    check("rst_q", bus_a.match_q, 0);
    now_log = '0;
    stream("100000");
    check("rst_now", now_log, 32'b000011);
    check("rst_after_count", bus_a.match_count, 2);

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
